keypad_matrix_scan: RTL and testbench

Parametrised matrix-keypad scanner for the front-panel input path. Drives one-hot column strobes, samples active-high row lines, and debounces whole-matrix frames. Emits single-cycle press/release events with a binary key code, optional auto-repeat, and a multi-key flag. Runs entirely on the system clock using a clock-enable tick, with no derived clocks, and feeds the same downstream decode logic as the earlier 4x3 scanner.

---
 rtl/keypad_matrix_scan_pkg.sv | 37 +++
 rtl/keypad_matrix_scan_if.sv | 33 +++
 rtl/keypad_matrix_scan_debounce.sv | 59 +++++
 rtl/keypad_matrix_scan.sv | 175 +++++++++++++++++
 tb/tb_keypad_matrix_scan.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_matrix_scan_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
// Code width, popcount and key-index helpers live here.
package keypad_pkg;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_PRESS,
    EV_RELEASE,
    EV_REPEAT
  } kp_event_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_OTHER
  } kp_state_e;

  function automatic int code_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int lowest_index(input logic [63:0] v);
    int idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_matrix_scan_if.sv
// Keypad pins plus the debounced key outputs.
// master = scanner, slave = pad ring / downstream decode.
interface keypad_matrix_scan_if
  import keypad_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 3
);
  localparam int N  = ROWS * COLS;
  localparam int CW = code_width(N);

  logic            en;
  logic [ROWS-1:0] key_row;
  logic [COLS-1:0] key_col;
  logic [N-1:0]    key_map;
  logic [CW-1:0]   key_code;
  logic            key_press;
  logic            key_release;
  logic            key_multi;

  modport master (
    input  en, key_row,
    output key_col, key_map, key_code,
    output key_press, key_release, key_multi
  );

  modport slave (
    output en, key_row,
    input  key_col, key_map, key_code,
    input  key_press, key_release, key_multi
  );

endinterface

// File: rtl/keypad_matrix_scan_debounce.sv
// Whole-frame debouncer: a frame must repeat DEBOUNCE
// times in a row before it replaces the debounced map.
module keypad_debounce #(
  parameter int W        = 12,
  parameter int DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done_i,
  input  logic         clr_i,
  input  logic [W-1:0] frame_i,
  output logic         upd_o,
  output logic [W-1:0] map_d_o,
  output logic [W-1:0] map_o
);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] map_q, map_d;
  logic [3:0]   cnt_q, cnt_d;

  // frame compare, saturating stable count, map load
  always_comb begin
    prev_d = prev_q;
    map_d  = map_q;
    cnt_d  = cnt_q;
    upd_o  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (done_i) begin
      prev_d = frame_i;
      if (frame_i == prev_q)
        cnt_d = (cnt_q >= DB) ? DB : cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
      if (cnt_d == DB && frame_i != map_q) begin
        map_d = frame_i;
        upd_o = 1'b1;
      end
    end
  end

  // debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      map_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      map_q  <= map_d;
      cnt_q  <= cnt_d;
    end
  end

  assign map_d_o = map_d;
  assign map_o   = map_q;

endmodule

// File: rtl/keypad_matrix_scan.sv
// Matrix keypad scanner: column strobe, frame capture,
// debounce, press/release/repeat events, multi-key flag.
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 3,
  parameter int SCAN_DIV    = 12500,
  parameter int DEBOUNCE    = 3,
  parameter int REPEAT_DLY  = 0,
  parameter int REPEAT_RATE = 8
) (
  input  logic clk,
  input  logic rst,
  keypad_matrix_scan_if.master bus
);
  localparam int N   = ROWS * COLS;
  localparam int CW  = code_width(N);
  localparam int CCW = code_width(COLS);
  localparam int PW  = code_width(SCAN_DIV);

  localparam logic [PW-1:0]  PMAX   = PW'(SCAN_DIV - 1);
  localparam logic [CCW-1:0] CMAX   = CCW'(COLS - 1);
  localparam logic [15:0]    RDLY   = 16'(REPEAT_DLY);
  localparam logic [15:0]    RRATE  = 16'(REPEAT_RATE);
  localparam bit             REP_EN = REPEAT_DLY > 0;

  logic [PW-1:0]  pre_q, pre_d;
  logic [CCW-1:0] col_q, col_d;
  logic [N-1:0]   frame_q, frame_d;
  logic [CW-1:0]  idx;
  logic           tick, done;

  logic           upd;
  logic [N-1:0]   map_q, map_d;
  int             pop_old, pop_new;

  kp_state_e      state_q, state_d;
  logic [15:0]    rpt_q, rpt_d, rpt_inc;
  logic           first_q, first_d;
  logic           rpt_fire;
  kp_event_e      ev_d;
  logic [CW-1:0]  code_q, code_d;
  logic           multi_q, multi_d;
  logic           press_q, press_d;
  logic           rel_q, rel_d;

  // prescaler, column sequencer and frame capture
  always_comb begin
    tick    = bus.en && (pre_q == PMAX);
    done    = tick && (col_q == CMAX);
    pre_d   = pre_q;
    col_d   = col_q;
    frame_d = frame_q;
    idx     = '0;
    if (!bus.en) begin
      col_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        col_d = (col_q == CMAX) ? '0 : col_q + 1'b1;
        for (int r = 0; r < ROWS; r++) begin
          idx = CW'(r * COLS) + CW'(col_q);
          frame_d[idx] = bus.key_row[r];
        end
      end
    end
  end

  // scan registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
    end else begin
      pre_q   <= pre_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end

  keypad_debounce #(
    .W        (N),
    .DEBOUNCE (DEBOUNCE)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .done_i  (done),
    .clr_i   (!bus.en),
    .frame_i (frame_d),
    .upd_o   (upd),
    .map_d_o (map_d),
    .map_o   (map_q)
  );

  assign pop_old = popcount(64'(map_q));
  assign pop_new = popcount(64'(map_d));

  // event FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rpt_q   <= '0;
      first_q <= 1'b0;
      code_q  <= '0;
      multi_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rpt_q   <= rpt_d;
      first_q <= first_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // event FSM next state and repeat timing
  always_comb begin
    state_d  = state_q;
    rpt_d    = rpt_q;
    first_d  = first_q;
    rpt_fire = 1'b0;
    rpt_inc  = rpt_q + 16'd1;
    if (upd) begin
      if (pop_new == 0) begin
        state_d = S_IDLE;
      end else if (pop_old == 0 && pop_new == 1) begin
        state_d = S_HELD;
        rpt_d   = '0;
        first_d = 1'b1;
      end else begin
        state_d = S_OTHER;
      end
    end else if (done && REP_EN && state_q == S_HELD) begin
      rpt_d = rpt_inc;
      if (first_q ? (rpt_inc == RDLY) : (rpt_inc == RRATE)) begin
        rpt_fire = 1'b1;
        rpt_d    = '0;
        first_d  = 1'b0;
      end
    end
  end

  // event FSM outputs
  always_comb begin
    ev_d    = EV_NONE;
    code_d  = code_q;
    multi_d = multi_q;
    if (upd) begin
      multi_d = pop_new > 1;
      if (pop_old == 0 && pop_new == 1) begin
        ev_d   = EV_PRESS;
        code_d = CW'(lowest_index(64'(map_d)));
      end else if (pop_old == 1 && pop_new == 0) begin
        ev_d = EV_RELEASE;
      end
    end else if (rpt_fire) begin
      ev_d = EV_REPEAT;
    end
    press_d = (ev_d == EV_PRESS) || (ev_d == EV_REPEAT);
    rel_d   = (ev_d == EV_RELEASE);
  end

  assign bus.key_col     = bus.en ? (COLS'(1) << col_q) : '0;
  assign bus.key_map     = map_q;
  assign bus.key_code    = code_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = rel_q;
  assign bus.key_multi   = multi_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Randomised scoreboard bench for keypad_matrix_scan.
// Keypad is modelled physically: rows = pressed & strobe.
module tb_keypad_matrix_scan;
  import keypad_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 3;
  localparam int SD    = 4;
  localparam int DEB   = 3;
  localparam int DLY   = 2;
  localparam int RATE  = 1;
  localparam int N     = ROWS * COLS;
  localparam int FRAME = COLS * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  keypad_matrix_scan #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .SCAN_DIV    (SD),
    .DEBOUNCE    (DEB),
    .REPEAT_DLY  (DLY),
    .REPEAT_RATE (RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [N-1:0] keys = '0;

  always_comb begin
    for (int r = 0; r < ROWS; r++)
      bus.key_row[r] = |(keys[r*COLS +: COLS] & bus.key_col);
  end

  typedef struct {
    int           kind;
    int           code;
    logic [N-1:0] map;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int en_cnt = 0;
  int tk = 0;
  int hf = 0;
  int mcode = 0;
  bit held = 0;
  logic [N-1:0] frame = '0;
  logic [N-1:0] mmap = '0;
  logic [N-1:0] hist[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic int first_key(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic push_ev(input int kind, input int code);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.map  = mmap;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  // frame-level reference: map follows the last DEB identical
  // frames; events from key counts; repeat from frames held
  task automatic end_of_frame();
    bit st;
    int o, n;
    hist.push_back(frame);
    if (hist.size() > DEB) void'(hist.pop_front());
    st = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != frame) st = 0;
    if (st && frame != mmap) begin
      o = $countones(mmap);
      n = $countones(frame);
      mmap = frame;
      if (o == 0 && n == 1) begin
        mcode = first_key(frame);
        held = 1;
        hf = 0;
        push_ev(1, mcode);
      end else begin
        held = 0;
        if (o == 1 && n == 0) push_ev(2, mcode);
      end
    end else if (held) begin
      hf++;
      if (hf == DLY || (hf > DLY && (hf - DLY) % RATE == 0))
        push_ev(1, mcode);
    end
  endtask

  always @(posedge clk) begin
    int c;
    cyc++;
    if (rst) begin
      en_cnt = 0;
      tk = 0;
      hf = 0;
      held = 0;
      mcode = 0;
      frame = '0;
      mmap = '0;
      hist.delete();
    end else if (!bus.en) begin
      tk = 0;
      hist.delete();
    end else begin
      en_cnt++;
      if (en_cnt % SD == 0) begin
        c = tk % COLS;
        for (int r = 0; r < ROWS; r++)
          frame[r*COLS+c] = keys[r*COLS+c];
        tk++;
        if (c == COLS - 1) end_of_frame();
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      chk("rst_col", 64'(bus.key_col), bus.en ? 64'd1 : 64'd0);
      chk("rst_map", 64'(bus.key_map), 64'd0);
      chk("rst_code", 64'(bus.key_code), 64'd0);
      chk("rst_press", 64'(bus.key_press), 64'd0);
      chk("rst_release", 64'(bus.key_release), 64'd0);
      chk("rst_multi", 64'(bus.key_multi), 64'd0);
    end else begin
      chk("key_col", 64'(bus.key_col),
          bus.en ? (64'd1 << (tk % COLS)) : 64'd0);
      chk("key_map", 64'(bus.key_map), 64'(mmap));
      chk("key_multi", 64'(bus.key_multi),
          64'($countones(mmap) > 1));
      chk("key_code", 64'(bus.key_code), 64'(mcode));
      chk("press_and_release", 64'(bus.key_press & bus.key_release),
          64'd0);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_event_cycle", 64'(cyc), 64'(e.cyc));
      end
      if (bus.key_press || bus.key_release) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {62'd0, bus.key_release,
              bus.key_press}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("event_kind", {62'd0, bus.key_release, bus.key_press},
              (e.kind == 1) ? 64'd1 : 64'd2);
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          chk("event_map", 64'(bus.key_map), 64'(e.map));
          chk("event_code", 64'(bus.key_code), 64'(e.code));
        end
      end
    end
  end

  task automatic waitc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k, k2, hold;
    bus.en = 1'b1;
    keys = '0;
    rst = 1'b1;
    waitc(3);
    rst = 1'b0;

    keys = N'(12'h008);
    waitc(6 * FRAME);
    keys = '0;
    waitc(5 * FRAME);

    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? N'(12'h008) : '0;
      waitc(FRAME);
    end
    keys = N'(12'h008);
    waitc(6 * FRAME);
    keys = '0;
    waitc(5 * FRAME);

    keys = N'(12'h001);
    waitc(5 * FRAME);
    keys = N'(12'h801);
    waitc(5 * FRAME);
    keys = '0;
    waitc(5 * FRAME);

    keys = N'(1) << 5;
    waitc(6 * FRAME);
    keys = '0;
    waitc(5 * FRAME);

    keys = N'(1) << 7;
    waitc(FRAME + 5);
    bus.en = 1'b0;
    waitc(10);
    bus.en = 1'b1;
    waitc(6 * FRAME);
    keys = '0;
    waitc(5 * FRAME);

    keys = N'(1) << 4;
    waitc(5 * FRAME);
    rst = 1'b1;
    waitc(2);
    rst = 1'b0;
    keys = '0;
    waitc(4 * FRAME);

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 9));
      k2 = int'($urandom_range(0, N - 1));
      if (k < 5)
        keys = N'(1) << k2;
      else if (k < 7)
        keys = (N'(1) << k2) |
               (N'(1) << $urandom_range(0, N - 1));
      else
        keys = '0;
      hold = int'($urandom_range(1, 6)) * FRAME +
             int'($urandom_range(0, FRAME - 1));
      if ($urandom_range(0, 7) == 0) begin
        waitc(hold / 2);
        bus.en = 1'b0;
        waitc(int'($urandom_range(1, 20)));
        bus.en = 1'b1;
        waitc(hold / 2);
      end else if ($urandom_range(0, 11) == 0) begin
        waitc(hold);
        rst = 1'b1;
        waitc(2);
        rst = 1'b0;
      end else begin
        waitc(hold);
      end
    end

    keys = '0;
    waitc(6 * FRAME);
    chk("events_outstanding", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
